// File: rtl/rom_loader.sv
// ROM download sequencer: ioctl words to DDR3 and SDRAM via toggle req/ack,
// plus cartridge metadata (size, header, SuperGrafx, Populous).
module rom_loader #(
    parameter int AW = 24
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cart_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [15:0]   ioctl_dout,
    input  logic          swap_en,
    output logic          ioctl_wait,
    output logic [AW-1:0] romwr_a,
    output logic [15:0]   romwr_d,
    output logic          rom_wr,
    input  logic          dd_wrack,
    input  logic          sd_wrack,
    output logic [7:0]    rom_sz,
    output logic          rom_hdr,
    output logic [1:0]    populous,
    output logic          sgx,
    output logic          load_done,
    output logic          wr_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-5:0] POP_A = (AW-4)'('h212);
    localparam logic [AW-5:0] POP_B = (AW-4)'('h1F2);

    state_t        state_q = IDLE;
    logic          dl_q    = 1'b0;
    logic          wait_q  = 1'b0;
    logic [AW-1:0] addr_q  = '0;
    logic [15:0]   data_q  = '0;
    logic          wr_q    = 1'b0;
    logic [1:0]    pop_q   = 2'b11;
    logic          sgx_q   = 1'b0;
    logic          ld_q    = 1'b0;
    logic          drop_q  = 1'b0;

    logic          start;
    logic          stop;
    logic          acked;
    logic          accept;
    logic          drop;
    logic [15:0]   sw_d;
    logic          pop_chk;
    logic [15:0]   pop_exp;
    logic          pop_bad;
    logic          unused_idx;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign unused_idx = ^ioctl_index[7:5];

    assign start  = cart_download & ~dl_q;
    assign stop   = ~cart_download & dl_q;
    assign acked  = (wr_q == dd_wrack) && (wr_q == sd_wrack);
    assign accept = ioctl_wr & cart_download & (state_q == IDLE)
                  & ~reset & ~start;
    assign drop   = ioctl_wr & (reset | start | (state_q != IDLE));
    assign sw_d   = swap_en ? {rev8(ioctl_dout[15:8]), rev8(ioctl_dout[7:0])}
                            : ioctl_dout;

    // Signature words of "POPULOUS" at offsets 6..12 of the probed lines
    always_comb begin
        pop_chk = 1'b1;
        pop_exp = 16'h0000;
        unique case (addr_q[3:0])
            4'h6:    pop_exp = 16'h4F50;
            4'h8:    pop_exp = 16'h5550;
            4'hA:    pop_exp = 16'h4F4C;
            4'hC:    pop_exp = 16'h5355;
            default: pop_chk = 1'b0;
        endcase
    end

    assign pop_bad = pop_chk & (sw_d != pop_exp)
                   & ((addr_q[AW-1:4] == POP_A) | (addr_q[AW-1:4] == POP_B));

    always_ff @(posedge clk_sys) begin
        dl_q <= cart_download;
        ld_q <= ~reset & stop;
        if (drop)
            drop_q <= 1'b1;
        else if (start & ~reset)
            drop_q <= 1'b0;

        if (reset) begin
            // Keep toggle phase aligned: drain any outstanding request
            wait_q  <= 1'b0;
            state_q <= acked ? IDLE : DRAIN;
        end else begin
            if (start) begin
                addr_q <= '0;
                pop_q  <= 2'b11;
                sgx_q  <= (ioctl_index[4:0] == 5'd2);
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= sw_d;
                        wr_q    <= ~wr_q;
                        wait_q  <= 1'b1;
                        state_q <= WAIT;
                        if (pop_bad)
                            pop_q[addr_q[13]] <= 1'b0;
                    end
                end
                WAIT: begin
                    if (acked) begin
                        wait_q  <= 1'b0;
                        state_q <= IDLE;
                        if (!start)
                            addr_q <= addr_q + AW'(2);
                    end
                end
                DRAIN: begin
                    if (acked)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ioctl_wait = wait_q;
    assign romwr_a    = addr_q;
    assign romwr_d    = data_q;
    assign rom_wr     = wr_q;
    assign rom_sz     = addr_q[23:16];
    assign rom_hdr    = addr_q[9];
    assign populous   = pop_q;
    assign sgx        = sgx_q;
    assign load_done  = ld_q;
    assign wr_drop    = drop_q;

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: vector table, randomized words with ack skew,
// and hand-written sequences for reset drain and metadata.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        cart_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_dout = '0;
    logic        swap_en = 1'b0;
    logic        ioctl_wait;
    logic [23:0] romwr_a;
    logic [15:0] romwr_d;
    logic        rom_wr;
    logic        dd_wrack = 1'b0;
    logic        sd_wrack = 1'b0;
    logic [7:0]  rom_sz;
    logic        rom_hdr;
    logic [1:0]  populous;
    logic        sgx;
    logic        load_done;
    logic        wr_drop;

    rom_loader #(.AW(24)) dut (
        .clk_sys(clk_sys), .reset(reset), .cart_download(cart_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .swap_en(swap_en),
        .ioctl_wait(ioctl_wait), .romwr_a(romwr_a), .romwr_d(romwr_d),
        .rom_wr(rom_wr), .dd_wrack(dd_wrack), .sd_wrack(sd_wrack),
        .rom_sz(rom_sz), .rom_hdr(rom_hdr), .populous(populous),
        .sgx(sgx), .load_done(load_done), .wr_drop(wr_drop)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;

    // reference model state
    int          m_addr = 0;
    logic        m_wr = 1'b0;
    logic [1:0]  m_pop = 2'b11;
    logic        m_sgx = 1'b0;
    logic        m_drop = 1'b0;
    logic [15:0] m_d = '0;

    typedef struct {
        logic [15:0] d;
        logic        sw;
        logic [15:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {<<{b}};
    endfunction

    function automatic logic [15:0] sig_word(input int off);
        string s;
        s = "POPULOUS";
        return {s[off-5], s[off-6]};
    endfunction

    function automatic logic [1:0] pop_upd(input int a, input logic [15:0] d,
                                           input logic [1:0] p);
        int off;
        logic [1:0] r;
        r = p;
        off = a & 15;
        if ((((a >> 4) == 'h212) || ((a >> 4) == 'h1F2)) &&
            off >= 6 && off <= 12 && (off % 2) == 0) begin
            if (d != sig_word(off))
                r[(a >> 13) & 1] = 1'b0;
        end
        return r;
    endfunction

    task automatic do_word(input logic [15:0] d, input logic sw,
                           input int dd, input int sd,
                           input bit extra, input bit quiet);
        logic [15:0] e;
        int cyc;
        int mx;
        ioctl_dout = d;
        swap_en = sw;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        e = sw ? {rev8(d[15:8]), rev8(d[7:0])} : d;
        m_pop = pop_upd(m_addr, e, m_pop);
        m_wr = ~m_wr;
        m_d = e;
        if (!quiet) begin
            chk("req_toggle", rom_wr, m_wr);
            chk("req_data", romwr_d, m_d);
            chk("req_wait", ioctl_wait, 1);
        end
        cyc = 0;
        do begin
            if (cyc == dd) dd_wrack = m_wr;
            if (cyc == sd) sd_wrack = m_wr;
            if (extra && cyc == 1) ioctl_wr = 1'b1;
            tick();
            if (extra && cyc == 1) m_drop = 1'b1;
            ioctl_wr = 1'b0;
            cyc++;
            if (!quiet && ioctl_wait) begin
                chk("hold_addr", romwr_a, m_addr);
                chk("hold_data", romwr_d, m_d);
            end
        end while (ioctl_wait && cyc < 64);
        mx = (dd > sd) ? dd : sd;
        m_addr = (m_addr + 2) & 'hFFFFFF;
        if (!quiet) begin
            chk("wait_len", cyc, mx + 1);
            chk("addr_inc", romwr_a, m_addr);
        end else if (cyc >= 64) begin
            chk("wait_len", cyc, mx + 1);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx, input bit with_wr);
        ioctl_index = idx;
        cart_download = 1'b1;
        ioctl_wr = with_wr;
        tick();
        ioctl_wr = 1'b0;
        m_addr = 0;
        m_pop = 2'b11;
        m_sgx = (idx[4:0] == 5'd2);
        m_drop = with_wr;
        chk("start_addr", romwr_a, 0);
        chk("start_pop", populous, 2'b11);
        chk("start_sgx", sgx, m_sgx);
        chk("start_drop", wr_drop, m_drop);
        chk("start_wr", rom_wr, m_wr);
    endtask

    task automatic end_dl();
        cart_download = 1'b0;
        tick();
        chk("done_pulse", load_done, 1);
        tick();
        chk("done_clear", load_done, 0);
        chk("final_size", romwr_a, m_addr);
        chk("final_pop", populous, m_pop);
    endtask

    task automatic pop_download(input bit corrupt);
        logic [15:0] d;
        start_dl(8'h01, 0);
        while (m_addr < 'h2130) begin
            if (m_addr >= 'h2126 && m_addr <= 'h212C)
                d = sig_word(m_addr & 15);
            else
                d = m_addr[15:0];
            if (corrupt && m_addr == 'h2128)
                d = 16'h0000;
            do_word(d, 1'b0, 0, 0, 0, 1);
        end
        end_dl();
    endtask

    vec_t vt[6];
    logic wr0;
    logic [23:0] a0;

    initial begin
        vt[0] = '{16'h0180, 1'b1, 16'h8001};
        vt[1] = '{16'h0180, 1'b0, 16'h0180};
        vt[2] = '{16'h1234, 1'b1, 16'h482C};
        vt[3] = '{16'hF00F, 1'b1, 16'h0FF0};
        vt[4] = '{16'hA5C3, 1'b1, 16'hA5C3};
        vt[5] = '{16'h0001, 1'b1, 16'h0080};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_wr", rom_wr, 0);
        chk("rst_addr", romwr_a, 0);
        chk("rst_data", romwr_d, 0);
        chk("rst_pop", populous, 2'b11);
        chk("rst_sgx", sgx, 0);
        chk("rst_drop", wr_drop, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_done", load_done, 0);

        // four words with immediate acks
        start_dl(8'h01, 0);
        wr0 = m_wr;
        for (int i = 0; i < 4; i++)
            do_word(16'h1000 + 16'(i), 1'b0, 0, 0, 0, 0);
        chk("four_addr", romwr_a, 8);
        chk("four_toggles", rom_wr, wr0);

        // bit-reversal vector table
        foreach (vt[i]) begin
            do_word(vt[i].d, vt[i].sw, 0, 0, 0, 0);
            chk("swap_vec", romwr_d, vt[i].exp);
        end

        // skewed acks with extra write during the wait
        do_word(16'hBEEF, 1'b0, 1, 7, 1, 0);
        chk("skew_drop", wr_drop, 1);
        end_dl();

        // start with same-cycle write, then random words
        start_dl(8'h05, 1);
        for (int i = 0; i < 40; i++)
            do_word(16'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5), $urandom_range(0, 5), 0, 0);
        chk("rand_drop", wr_drop, m_drop);
        end_dl();

        // reset while a request is outstanding
        start_dl(8'h01, 0);
        do_word(16'h2222, 1'b0, 0, 0, 0, 0);
        ioctl_dout = 16'h1357;
        swap_en = 1'b0;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        m_wr = ~m_wr;
        m_d = 16'h1357;
        a0 = romwr_a;
        tick();
        reset = 1'b1;
        ioctl_wr = 1'b1;
        tick();
        reset = 1'b0;
        ioctl_wr = 1'b0;
        m_drop = 1'b1;
        chk("rstw_wait", ioctl_wait, 0);
        chk("rstw_addr", romwr_a, m_addr);
        chk("rstw_wr", rom_wr, m_wr);
        chk("rstw_drop", wr_drop, 1);
        chk("rstw_data", romwr_d, m_d);
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("drain_ignore", rom_wr, m_wr);
        chk("drain_wait", ioctl_wait, 0);
        dd_wrack = m_wr;
        sd_wrack = m_wr;
        tick();
        tick();
        chk("drain_noinc", romwr_a, a0);
        do_word(16'h4444, 1'b0, 0, 0, 0, 0);
        end_dl();

        // Populous signature, clean and corrupted
        pop_download(0);
        chk("pop_clean", populous, 2'b10);
        pop_download(1);
        chk("pop_corrupt", populous, 2'b00);

        // SuperGrafx index with copier header
        start_dl(8'h22, 0);
        chk("sgx_set", sgx, 1);
        for (int i = 0; i < 256; i++)
            do_word(16'(i * 3), 1'b0, 0, 0, 0, 1);
        end_dl();
        chk("hdr_flag", rom_hdr, 1);
        chk("hdr_size", rom_sz, 0);
        chk("hdr_addr", romwr_a, 'h200);
        chk("hdr_sgx", sgx, 1);
        tick();
        chk("hdr_done_once", load_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Write-side ROM download sequencer between the HPS ioctl stream and the two ROM backends (DDR3 and SDRAM controllers). It accepts 16-bit cartridge words and applies the optional per-byte bit reversal. Each word goes to both backends through a toggle req/ack handshake, and the ioctl stream is throttled with `ioctl_wait` until both backends acknowledge. While streaming it also derives cartridge metadata for the core: write address/size, header offset, SuperGrafx flag and Populous detection.

## Interface
Parameters:
- `AW`, 24: write address width (byte address, word-aligned).

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cart_download` in 1: ROM download in progress (non-cheat ioctl index).
- `ioctl_index` in 8: download index; `[4:0]==2` selects SuperGrafx.
- `ioctl_wr` in 1: one-cycle strobe, `ioctl_dout` valid.
- `ioctl_dout` in 16: download word.
- `swap_en` in 1: bit-reverse each byte of the data.
- `ioctl_wait` out 1: stall to HPS.
- `romwr_a` out AW: current word byte address.
- `romwr_d` out 16: data presented to both backends, held stable until acked.
- `rom_wr` out 1: write request toggle.
- `dd_wrack` in 1: DDR3 ack toggle.
- `sd_wrack` in 1: SDRAM ack toggle.
- `rom_sz` out 8: `romwr_a[23:16]`.
- `rom_hdr` out 1: `romwr_a[9]` (512-byte copier header present).
- `populous` out 2: Populous signature match, [1] at 0x212x, [0] at 0x1F2x.
- `sgx` out 1: SuperGrafx image.
- `load_done` out 1: one-cycle pulse when the download ends.
- `wr_drop` out 1: sticky; a write was ignored.

## Operation
- States:
  - IDLE: ready for a word.
  - WAIT: request outstanding.
  - DRAIN: reset hit mid-request; waiting for backends.
- Download start: `cart_download` rising edge (vs registered copy). Sets `romwr_a`=0, `populous`=2'b11, `sgx`=(`ioctl_index[4:0]==2`) and `wr_drop`=0. Start has priority over a same-cycle `ioctl_wr`, which is dropped and sets `wr_drop`.
- Word accept happens in IDLE when `ioctl_wr & cart_download`:
  - Latch `romwr_d` from `ioctl_dout`. When `swap_en`=1, each byte is bit-reversed in place: `romwr_d[15:8]`=rev(`dout[15:8]`), `romwr_d[7:0]`=rev(`dout[7:0]`).
  - Toggle `rom_wr`, set `ioctl_wait`=1, go to WAIT.
- Populous check on accept: applies when `romwr_a[23:4]` is 0x212 or 0x1F2.
  - Offsets `[3:0]` 6/8/10/12 must carry 0x4F50/0x5550/0x4F4C/0x5355. Any mismatch clears `populous[romwr_a[13]]`.
  - The compare uses post-swap data.
  - Bits are never set again until the next download start.
- WAIT → IDLE when `rom_wr==dd_wrack && rom_wr==sd_wrack`: `ioctl_wait`=0 and `romwr_a` += 2, wrapping modulo 2^AW.
- An `ioctl_wr` while in WAIT or DRAIN, or while `reset` is high, is ignored and sets `wr_drop`.
- Download end: `cart_download` falling edge pulses `load_done` for one cycle. `romwr_a` then holds the final image size.
- Reset:
  - Forces `ioctl_wait`=0 and `load_done`=0.
  - Next state is DRAIN if either ack ≠ `rom_wr`, else IDLE.
  - DRAIN → IDLE once both acks match, with no `romwr_a` increment.
  - Reset does not alter `rom_wr`, `romwr_a`, `romwr_d`, `populous`, `sgx` or `wr_drop`. The core reset must not lose ROM size or flags, and the toggle phase must stay matched to the backends.
- Power-up values: `rom_wr`=0, `romwr_a`=0, `romwr_d`=0, `populous`=2'b11, `sgx`=0, `wr_drop`=0, state IDLE.

## Timing
- Accept at edge N (`ioctl_wr` sampled high): `rom_wr`, `romwr_d` and `ioctl_wait` update at N.
- Acks are sampled registered. With both acks matching at edge M>N, `ioctl_wait` falls and `romwr_a` increments at M.
- Minimum word period is 2 cycles.
- `romwr_d` and `romwr_a` are stable from request toggle until ack match.
- Acks may arrive in either order or in the same cycle. Completion requires both.
- `rom_sz` and `rom_hdr` are combinational from `romwr_a`.
- `load_done` asserts the cycle after `cart_download` is first sampled low.

## Test plan
- Word stream with immediate acks: after 4 words from start, `romwr_a`=8, `ioctl_wait` high exactly 1 cycle per word, `rom_wr` toggles 4 times.
- `swap_en`=1, `dout`=0x0180: `romwr_d`=0x8001. With `swap_en`=0, `romwr_d`=0x0180.
- Skewed acks (DDR +1 cycle, SDRAM +7 cycles): `ioctl_wait` holds until the SDRAM ack, then `romwr_a` increments once. An extra `ioctl_wr` during the wait sets `wr_drop`.
- Populous: write "POPULOUS" words at 0x2126..0x212C → `populous`=2'b10 after the end. Corrupting 0x2128 instead gives 2'b00.
- Index 2 download of 0x80200 bytes: `sgx`=1, `rom_sz`=0x08, `rom_hdr`=1, one `load_done` pulse.
- `reset` asserted in WAIT with acks pending: `ioctl_wait`=0 next cycle, state DRAIN. `romwr_a` and `rom_wr` are unchanged, and IDLE follows the ack with no increment.
